multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Main control FSM for the multi-cycle RV32I-subset core. Sequences the shared ALU, instruction register, PC, register file and unified memory port through fetch, decode, execute, memory and writeback steps. Drives the ALU through the team's existing ALU-control decoder, which maps `alu_op`, `funct3` and `funct7b5` to the 4-bit `alu_control` code. Supports lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq and jal. Any other opcode traps.

## Interface

No parameters.

Ports:

- `clk`  in  1  single clock; everything is on the rising edge.
- `rst_n`  in  1  reset: synchronous, active-low.
- `op`  in  7  opcode, taken from the instruction register.
- `funct3`  in  3  instruction bits [14:12].
- `funct7b5`  in  1  instruction bit 30.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory accepts or completes the current access this cycle.
- `pc_write`  out  1  PC register enable.
- `adr_src`  out  1  memory address select: 0 = PC, 1 = ALU result register.
- `mem_write`  out  1  memory write strobe.
- `ir_write`  out  1  instruction register enable; old-PC is captured at the same time.
- `result_src`  out  2  result mux: 00 = ALUOut, 01 = mem data, 10 = ALU result.
- `alu_src_a`  out  2  ALU A input: 00 = PC, 01 = old PC, 10 = rs1.
- `alu_src_b`  out  2  ALU B input: 00 = rs2, 01 = immediate, 10 = constant 4.
- `imm_src`  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- `reg_write`  out  1  register file write enable.
- `alu_control`  out  4  ALU operation code: ADD 0010, SUB 0110, AND 0000, OR 0001, SLT 0111.
- `retire`  out  1  one-cycle pulse on the final cycle of every completed instruction.
- `illegal`  out  1  sticky trap flag.

## Operation

State register: 4 bits. States are FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, JAL, ALUWB, BEQ, TRAP.

Outputs are Moore functions of the state. Two exceptions: `mem_ready` gating and `zero`.

Unlisted outputs are 0 in every state. An unlisted `alu_op` is 00.

- **FETCH**
  - Outputs: `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `alu_op`=00, `result_src`=10.
  - `ir_write` = `mem_ready`; `pc_write` = `mem_ready`.
  - Go to DECODE when `mem_ready`=1, else stay.
- **DECODE**
  - Outputs: `alu_src_a`=01, `alu_src_b`=01, `alu_op`=00 (computes the branch target).
  - Next state by `op`:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1101111 → JAL
    - 1100011 → BEQ
    - anything else → TRAP
- **MEMADR**
  - Outputs: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=00.
  - Next: lw → MEMREAD, sw → MEMWRITE.
- **MEMREAD**
  - Outputs: `adr_src`=1.
  - Go to MEMWB on `mem_ready`, else stay.
- **MEMWB**
  - Outputs: `result_src`=01, `reg_write`=1, `retire`=1.
  - Next: FETCH.
- **MEMWRITE**
  - Outputs: `adr_src`=1, `mem_write`=1, held until `mem_ready`.
  - On `mem_ready`: `retire`=1, go to FETCH.
- **EXECR**
  - Outputs: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10.
  - Next: ALUWB.
- **EXECI**
  - Outputs: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=10.
  - The decoder's `funct7b5` input is forced to 0, so addi never subtracts.
  - Next: ALUWB.
- **JAL**
  - Outputs: `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00, `pc_write`=1.
  - Next: ALUWB.
- **ALUWB**
  - Outputs: `result_src`=00, `reg_write`=1, `retire`=1.
  - Next: FETCH.
- **BEQ**
  - Outputs: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `pc_write` = `zero`, `retire`=1.
  - Next: FETCH.
- **TRAP**
  - `illegal`=1; all write enables are 0.
  - Stays in TRAP until reset.

`imm_src` is decoded combinationally from `op` in every state:

- lw and I-type → 00
- sw → 01
- beq → 10
- jal → 11
- all others → 00

## Timing

- **Reset values:** a rising edge with `rst_n`=0 loads state FETCH and clears `illegal`.
- **Reset gating:** while `rst_n`=0, `pc_write`, `ir_write`, `mem_write`, `reg_write` and `retire` are forced to 0 combinationally. This suppresses writes during a reset asserted mid-instruction. The in-flight instruction is abandoned.
- **Cycles per instruction with `mem_ready` held at 1:**
  - lw 5
  - sw 4
  - R-type 4
  - I-type 4
  - jal 4
  - beq 3
- **Memory wait states:** each cycle with `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. All outputs are held stable during those cycles.
- **Input sampling:**
  - `op`, `funct3` and `funct7b5` are only used from DECODE onward; the IR is stable then.
  - `zero` is only sampled in BEQ.
- **Single-write rules:**
  - `retire` is high for exactly one cycle per instruction.
  - `reg_write` is asserted for exactly one cycle per lw, R-type, I-type or jal.

## Test plan

- **Reset:** hold `rst_n`=0 for 2 cycles with `mem_ready`=1.
  - Required: all write enables are 0 throughout.
  - Required: in the first cycle after release, `ir_write`=1, `pc_write`=1, `alu_src_b`=10, `alu_control`=0010.
- **R-type sub:** `op`=0110011, `funct3`=000, `funct7b5`=1.
  - Required: the instruction takes 4 cycles.
  - Required: `alu_control`=0110 in EXECR.
  - Required: `reg_write`=1 and `retire`=1 in cycle 4 only.
- **addi with bit 30 set:** `op`=0010011, `funct3`=000, `funct7b5`=1.
  - Required: `alu_control`=0010 in EXECI (not SUB).
  - Required: `imm_src`=00.
- **lw with memory wait:** `mem_ready` held low for 3 cycles in MEMREAD.
  - Required: the instruction takes 8 cycles total.
  - Required: `adr_src`=1 is held throughout MEMREAD.
  - Required: `reg_write` pulses once, with `result_src`=01.
- **beq:** run once with `zero`=1 and once with `zero`=0.
  - Required: the instruction takes 3 cycles.
  - Required: `alu_control`=0110 in BEQ.
  - Required: `pc_write`=1 in BEQ for the `zero`=1 case; `pc_write`=0 for the `zero`=0 case.
- **Illegal opcode:** `op`=0000000.
  - Required: TRAP is entered after DECODE and `illegal`=1 from then on.
  - Required: no write enables for 10 further cycles.
  - Required: `rst_n`=0 for one edge clears `illegal` and returns the FSM to FETCH.

Source files
------------

// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle RV32I-subset core: sequences fetch, decode,
// execute, memory and writeback steps and drives the ALU-control decoder.
module multicycle_controller (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       adr_src_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic [1:0] result_src_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] imm_src_o,
    output logic       reg_write_o,
    output logic [3:0] alu_control_o,
    output logic       retire_o,
    output logic       illegal_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_JAL      = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    state_t     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic [1:0] alu_op;
    logic       force_f7_zero;
    logic       f7b5_eff;
    logic       pc_write_raw, ir_write_raw, mem_write_raw, reg_write_raw, retire_raw;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready_i) state_d = S_DECODE;
            S_DECODE: begin
                case (op_i)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (op_i == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready_i) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready_i) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            // A corrupted state encoding is treated as a trap rather than silently resumed.
            default:    state_d = S_TRAP;
        endcase
    end

    assign illegal_d = illegal_q | (state_d == S_TRAP);

    always_comb begin
        pc_write_raw  = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        retire_raw    = 1'b0;
        adr_src_o     = 1'b0;
        result_src_o  = 2'b00;
        alu_src_a_o   = 2'b00;
        alu_src_b_o   = 2'b00;
        alu_op        = 2'b00;
        force_f7_zero = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b_o  = 2'b10;
                result_src_o = 2'b10;
                ir_write_raw = mem_ready_i;
                pc_write_raw = mem_ready_i;
            end
            S_DECODE: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
            end
            S_MEMREAD:  adr_src_o = 1'b1;
            S_MEMWB: begin
                result_src_o  = 2'b01;
                reg_write_raw = 1'b1;
                retire_raw    = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src_o     = 1'b1;
                mem_write_raw = 1'b1;
                retire_raw    = mem_ready_i;
            end
            S_EXECR: begin
                alu_src_a_o = 2'b10;
                alu_op      = 2'b10;
            end
            S_EXECI: begin
                alu_src_a_o   = 2'b10;
                alu_src_b_o   = 2'b01;
                alu_op        = 2'b10;
                force_f7_zero = 1'b1;
            end
            S_JAL: begin
                alu_src_a_o  = 2'b01;
                alu_src_b_o  = 2'b10;
                pc_write_raw = 1'b1;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                retire_raw    = 1'b1;
            end
            S_BEQ: begin
                alu_src_a_o  = 2'b10;
                alu_op       = 2'b01;
                pc_write_raw = zero_i;
                retire_raw   = 1'b1;
            end
            default: ;
        endcase
    end

    // Bit 30 of an I-type word is immediate data, so it must not select SUB.
    always_comb begin
        f7b5_eff = funct7b5_i & ~force_f7_zero;
        case (alu_op)
            2'b00: alu_control_o = ALU_ADD;
            2'b01: alu_control_o = ALU_SUB;
            2'b10: begin
                case (funct3_i)
                    3'b000:  alu_control_o = f7b5_eff ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

    always_comb begin
        case (op_i)
            OP_SW:   imm_src_o = 2'b01;
            OP_BEQ:  imm_src_o = 2'b10;
            OP_JAL:  imm_src_o = 2'b11;
            default: imm_src_o = 2'b00;
        endcase
    end

    assign pc_write_o  = pc_write_raw  & rst_ni;
    assign ir_write_o  = ir_write_raw  & rst_ni;
    assign mem_write_o = mem_write_raw & rst_ni;
    assign reg_write_o = reg_write_raw & rst_ni;
    assign retire_o    = retire_raw    & rst_ni;
    assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: instruction table, hand-written
// corner sequences and randomized instructions against a cycle-count reference model.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, retire, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [3:0] alu_control;

    int checks = 0;
    int failures = 0;

    localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_JAL = 4, C_BEQ = 5;

    multicycle_controller dut (
        .clk_i(clk), .rst_ni(rst_n), .op_i(op), .funct3_i(funct3),
        .funct7b5_i(funct7b5), .zero_i(zero), .mem_ready_i(mem_ready),
        .pc_write_o(pc_write), .adr_src_o(adr_src), .mem_write_o(mem_write),
        .ir_write_o(ir_write), .result_src_o(result_src), .alu_src_a_o(alu_src_a),
        .alu_src_b_o(alu_src_b), .imm_src_o(imm_src), .reg_write_o(reg_write),
        .alu_control_o(alu_control), .retire_o(retire), .illegal_o(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required=<100000", $time);
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] op_of(input int cls);
        case (cls)
            C_LW:    return 7'b0000011;
            C_SW:    return 7'b0100011;
            C_R:     return 7'b0110011;
            C_I:     return 7'b0010011;
            C_JAL:   return 7'b1101111;
            default: return 7'b1100011;
        endcase
    endfunction

    function automatic int cls_of(input logic [6:0] o);
        for (int c = 0; c < 6; c++) if (op_of(c) == o) return c;
        return -1;
    endfunction

    // Cycle counts with no wait states: lw 5, sw/R/I/jal 4, beq 3.
    function automatic int base_cpi(input int cls);
        case (cls)
            C_LW:    return 5;
            C_BEQ:   return 3;
            default: return 4;
        endcase
    endfunction

    function automatic int exp_alu(input int cls, input logic [2:0] f3, input logic f7);
        if (cls == C_BEQ) return 6;
        if (cls != C_R && cls != C_I) return 2;
        case (f3)
            3'b000:  return (cls == C_R && f7) ? 6 : 2;
            3'b010:  return 7;
            3'b110:  return 1;
            3'b111:  return 0;
            default: return 2;
        endcase
    endfunction

    function automatic int exp_imm(input int cls);
        case (cls)
            C_SW:    return 1;
            C_BEQ:   return 2;
            C_JAL:   return 3;
            default: return 0;
        endcase
    endfunction

    // Runs one instruction starting in FETCH. fw = fetch wait cycles, mw = memory wait
    // cycles (lw/sw only). zsel: 0/1 fixed zero flag, 2 random per cycle.
    task automatic run_instr(input logic [6:0] iop, input logic [2:0] if3, input logic if7,
                             input int fw, input int mw, input int zsel,
                             output int cyc, output int alu_x, output int imm_x,
                             output int pcw_x, output int rw_cnt, output int rs_rw,
                             output int adr_cnt);
        int cls, total, last, x, mlo, mhi;
        bit mem;
        logic mr, znow;
        cls   = cls_of(iop);
        mem   = (cls == C_LW || cls == C_SW);
        total = base_cpi(cls) + fw + (mem ? mw : 0);
        last  = total - 1;
        x     = fw + 2;
        mlo   = fw + 3;
        mhi   = fw + 3 + mw;
        op = iop; funct3 = if3; funct7b5 = if7;
        cyc = -1; alu_x = -1; imm_x = -1; pcw_x = -1; rw_cnt = 0; rs_rw = -1; adr_cnt = 0;
        for (int k = 0; k <= last + 3 && cyc < 0; k++) begin
            if (k < fw) mr = 1'b0;
            else if (k == fw) mr = 1'b1;
            else if (mem && k >= mlo && k < mhi) mr = 1'b0;
            else if (mem && k == mhi) mr = 1'b1;
            else mr = 1'($urandom_range(0, 1));
            znow = (zsel == 2) ? 1'($urandom_range(0, 1)) : (zsel == 1);
            mem_ready = mr;
            zero = znow;
            @(negedge clk);
            chk("ir_write", int'(ir_write), int'(k == fw));
            chk("pc_write", int'(pc_write),
                int'((k == fw) || (k == x && (cls == C_JAL || (cls == C_BEQ && znow)))));
            chk("mem_write", int'(mem_write), int'(cls == C_SW && k >= mlo && k <= last));
            chk("reg_write", int'(reg_write), int'(k == last && cls != C_SW && cls != C_BEQ));
            chk("retire", int'(retire), int'(k == last));
            chk("adr_src", int'(adr_src), int'(mem && k >= mlo && k <= mhi));
            chk("imm_src", int'(imm_src), exp_imm(cls));
            chk("illegal", int'(illegal), 0);
            if (k <= fw) begin
                chk("fetch_alu_src_b", int'(alu_src_b), 2);
                chk("fetch_result_src", int'(result_src), 2);
                chk("fetch_alu_control", int'(alu_control), 2);
            end
            if (k == x) begin
                chk("exec_alu_control", int'(alu_control), exp_alu(cls, if3, if7));
                chk("exec_alu_src_a", int'(alu_src_a), (cls == C_JAL) ? 1 : 2);
                alu_x = int'(alu_control);
                imm_x = int'(imm_src);
                pcw_x = int'(pc_write);
            end
            if (k == last) chk("last_result_src", int'(result_src), (cls == C_LW) ? 1 : 0);
            if (reg_write) begin
                rw_cnt++;
                rs_rw = int'(result_src);
            end
            if (adr_src) adr_cnt++;
            if (retire) cyc = k + 1;
            @(posedge clk); #1;
        end
        chk("model_cycles", cyc, total);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        string      nm;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        int         cpi;
        int         alu;
        int         imm;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int cyc, alu_x, imm_x, pcw_x, rw_cnt, rs_rw, adr_cnt, en_sum;

        tbl[0]  = '{"add",  7'b0110011, 3'b000, 1'b0, 4, 2, 0};
        tbl[1]  = '{"sub",  7'b0110011, 3'b000, 1'b1, 4, 6, 0};
        tbl[2]  = '{"and",  7'b0110011, 3'b111, 1'b0, 4, 0, 0};
        tbl[3]  = '{"or",   7'b0110011, 3'b110, 1'b0, 4, 1, 0};
        tbl[4]  = '{"slt",  7'b0110011, 3'b010, 1'b0, 4, 7, 0};
        tbl[5]  = '{"addi", 7'b0010011, 3'b000, 1'b1, 4, 2, 0};
        tbl[6]  = '{"andi", 7'b0010011, 3'b111, 1'b0, 4, 0, 0};
        tbl[7]  = '{"ori",  7'b0010011, 3'b110, 1'b1, 4, 1, 0};
        tbl[8]  = '{"slti", 7'b0010011, 3'b010, 1'b0, 4, 7, 0};
        tbl[9]  = '{"lw",   7'b0000011, 3'b010, 1'b0, 5, 2, 0};
        tbl[10] = '{"sw",   7'b0100011, 3'b010, 1'b0, 4, 2, 1};
        tbl[11] = '{"jal",  7'b1101111, 3'b000, 1'b0, 4, 2, 3};
        tbl[12] = '{"beq",  7'b1100011, 3'b000, 1'b0, 3, 6, 2};

        // Reset held for two edges with memory ready: no write may leak out.
        rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0;
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            en_sum = int'(pc_write) + int'(ir_write) + int'(mem_write) + int'(reg_write) + int'(retire);
            chk("reset_enables", en_sum, 0);
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ir_write", int'(ir_write), 1);
        chk("post_reset_pc_write", int'(pc_write), 1);
        chk("post_reset_alu_src_b", int'(alu_src_b), 2);
        chk("post_reset_alu_control", int'(alu_control), 2);
        chk("post_reset_illegal", int'(illegal), 0);
        @(posedge clk); #1;
        do_reset();

        foreach (tbl[i]) begin
            run_instr(tbl[i].op, tbl[i].f3, tbl[i].f7, 0, 0, 2,
                      cyc, alu_x, imm_x, pcw_x, rw_cnt, rs_rw, adr_cnt);
            chk({tbl[i].nm, "_cycles"}, cyc, tbl[i].cpi);
            chk({tbl[i].nm, "_alu_control"}, alu_x, tbl[i].alu);
            chk({tbl[i].nm, "_imm_src"}, imm_x, tbl[i].imm);
        end

        // lw with three memory wait states.
        run_instr(7'b0000011, 3'b010, 1'b0, 0, 3, 0, cyc, alu_x, imm_x, pcw_x, rw_cnt, rs_rw, adr_cnt);
        chk("lw_wait_cycles", cyc, 8);
        chk("lw_wait_reg_write_pulses", rw_cnt, 1);
        chk("lw_wait_result_src", rs_rw, 1);
        chk("lw_wait_adr_src_cycles", adr_cnt, 4);

        // beq taken and not taken.
        run_instr(7'b1100011, 3'b000, 1'b0, 0, 0, 1, cyc, alu_x, imm_x, pcw_x, rw_cnt, rs_rw, adr_cnt);
        chk("beq_z1_cycles", cyc, 3);
        chk("beq_z1_alu_control", alu_x, 6);
        chk("beq_z1_pc_write", pcw_x, 1);
        run_instr(7'b1100011, 3'b000, 1'b0, 0, 0, 0, cyc, alu_x, imm_x, pcw_x, rw_cnt, rs_rw, adr_cnt);
        chk("beq_z0_cycles", cyc, 3);
        chk("beq_z0_pc_write", pcw_x, 0);

        // Reset arriving during MEMWRITE must suppress the write strobe and retire.
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; mem_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_mem_write", int'(mem_write), 0);
        chk("midreset_retire", int'(retire), 0);
        chk("midreset_adr_src", int'(adr_src), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Randomized instruction stream with random wait states.
        for (int n = 0; n < 60; n++) begin
            int cls;
            cls = $urandom_range(0, 5);
            run_instr(op_of(cls), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), $urandom_range(0, 3), 2,
                      cyc, alu_x, imm_x, pcw_x, rw_cnt, rs_rw, adr_cnt);
            chk("rand_reg_write_pulses", rw_cnt, (cls == C_SW || cls == C_BEQ) ? 0 : 1);
        end

        // Illegal opcode: trap after decode, sticky until reset.
        op = 7'b0000000; funct3 = 3'b000; funct7b5 = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        chk("trap_fetch_ir_write", int'(ir_write), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("trap_decode_illegal", int'(illegal), 0);
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            zero = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("trap_illegal", int'(illegal), 1);
            en_sum = int'(pc_write) + int'(ir_write) + int'(mem_write) + int'(reg_write) + int'(retire);
            chk("trap_enables", en_sum, 0);
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("trap_sticky_before_edge", int'(illegal), 1);
        @(posedge clk); #1;
        rst_n = 1'b1; mem_ready = 1'b1; op = 7'b0110011;
        @(negedge clk);
        chk("trap_cleared_illegal", int'(illegal), 0);
        chk("trap_cleared_fetch_ir_write", int'(ir_write), 1);
        @(posedge clk); #1;
        do_reset();
        run_instr(7'b0110011, 3'b000, 1'b1, 1, 0, 2, cyc, alu_x, imm_x, pcw_x, rw_cnt, rs_rw, adr_cnt);
        chk("after_trap_sub_cycles", cyc, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
